// File: rtl/sd_cmd_sequencer.sv
// SD SPI command sequencer: frames a 6-byte command, sends it through the byte transmitter, then collects 1-5 response bytes.
// Each engine gets a one-cycle strobe and the engine's done flag is waited on; a stalled response byte is aborted after TIMEOUT_CYCLES.
module sd_cmd_sequencer #(
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   input  logic [6:0]  cmd_crc,
   input  logic [2:0]  resp_bytes,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [39:0] resp,
   output logic        cs_n,
   output logic        tx_en,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   output logic        rx_en,
   output logic        rx_reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_done
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      TX_PULSE,
      TX_WAIT,
      RX_PULSE,
      RX_WAIT,
      FINISH
   } state_t;

   state_t        state;
   logic [39:0]   frame_rest;
   logic [2:0]    idx;
   logic [2:0]    rx_len;
   logic [2:0]    rx_cnt;
   logic [TW-1:0] tcnt;
   logic [2:0]    len_clamped;

   always_comb begin
      len_clamped = resp_bytes;
      if (resp_bytes == 3'd0)
         len_clamped = 3'd1;
      else if (resp_bytes > 3'd5)
         len_clamped = 3'd5;
   end

   // tcnt holds the number of cycles elapsed since the current rx_en strobe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         frame_rest <= '0;
         idx        <= '0;
         rx_len     <= '0;
         rx_cnt     <= '0;
         tcnt       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         resp       <= '0;
         cs_n       <= 1'b1;
         tx_en      <= 1'b0;
         tx_data    <= '0;
         rx_en      <= 1'b0;
         rx_reset   <= 1'b0;
      end else begin
         tx_en    <= 1'b0;
         rx_en    <= 1'b0;
         rx_reset <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  frame_rest <= {cmd_arg, cmd_crc, 1'b1};
                  rx_len     <= len_clamped;
                  idx        <= '0;
                  rx_cnt     <= '0;
                  resp       <= '0;
                  timeout    <= 1'b0;
                  busy       <= 1'b1;
                  cs_n       <= 1'b0;
                  tx_en      <= 1'b1;
                  tx_data    <= {2'b01, cmd_index};
                  state      <= TX_PULSE;
               end
            end
            TX_PULSE: state <= TX_WAIT;
            TX_WAIT: begin
               if (tx_done) begin
                  if (idx == 3'd5) begin
                     rx_en <= 1'b1;
                     tcnt  <= '0;
                     state <= RX_PULSE;
                  end else begin
                     idx        <= idx + 3'd1;
                     tx_en      <= 1'b1;
                     tx_data    <= frame_rest[39:32];
                     frame_rest <= {frame_rest[31:0], 8'h00};
                     state      <= TX_PULSE;
                  end
               end
            end
            RX_PULSE: begin
               tcnt  <= tcnt + 1'b1;
               state <= RX_WAIT;
            end
            RX_WAIT: begin
               tcnt <= tcnt + 1'b1;
               // a byte landing in the last allowed cycle is still taken
               if (rx_done) begin
                  resp   <= {resp[31:0], rx_data};
                  rx_cnt <= rx_cnt + 3'd1;
                  if (rx_cnt + 3'd1 == rx_len) begin
                     done  <= 1'b1;
                     cs_n  <= 1'b1;
                     state <= FINISH;
                  end else begin
                     rx_en <= 1'b1;
                     tcnt  <= '0;
                     state <= RX_PULSE;
                  end
               end else if (tcnt == TLAST) begin
                  rx_reset <= 1'b1;
                  timeout  <= 1'b1;
                  done     <= 1'b1;
                  cs_n     <= 1'b1;
                  state    <= FINISH;
               end
            end
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
